// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs decoded field bundles into 32-bit words and
// streams them with sequential word addresses toward an instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              done_o,
  output logic              err_o
);

  // One extra bit so the count can hold DEPTH itself when DEPTH == 2**ADDR_W.
  localparam int                 CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_RTYPE   = 3'd0,
    OP_ORI     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_LW      = 3'd3,
    OP_SW      = 3'd4,
    OP_BEQ     = 3'd5,
    OP_J       = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [31:0] encode(
    input op_e         op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    word = 32'h0;
    unique case (op)
      OP_RTYPE:   word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      OP_ORI:     word = {6'b001101, rs, rt, imm};
      OP_ADDI:    word = {6'b001000, rs, rt, imm};
      OP_LW:      word = {6'b100011, rs, rt, imm};
      OP_SW:      word = {6'b101011, rs, rt, imm};
      OP_BEQ:     word = {6'b000100, rs, rt, imm};
      OP_J:       word = {6'b000010, target};
      OP_ILLEGAL: word = 32'h0;
      default:    word = 32'h0;
    endcase
    return word;
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  op_e                op;
  logic               accept;
  logic               consume;
  logic               legal_accept;
  logic               illegal_accept;
  logic [31:0]        encoded;

  assign op             = op_e'(op_i);
  assign in_ready_o     = !done_q && (!valid_q || instr_ready_i);
  assign accept         = in_valid_i && in_ready_o;
  assign consume        = valid_q && instr_ready_i;
  assign legal_accept   = accept && (op != OP_ILLEGAL);
  assign illegal_accept = accept && (op == OP_ILLEGAL);
  assign encoded        = encode(op, rs_i, rt_i, rd_i, funct_i, imm_i, target_i);

  // NOTE: every next-state signal is defaulted to its register first, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;

    if (clear_i) begin
      state_d = ST_EMPTY;
      count_d = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (consume) begin
        count_d = count_q + CNT_W'(1);
        valid_d = 1'b0;
        state_d = ST_EMPTY;
      end
      if (illegal_accept) begin
        err_d = 1'b1;
      end
      if (legal_accept) begin
        instr_d = encoded;
        valid_d = 1'b1;
        state_d = ST_FULL;
      end
      // Reaching DEPTH wins over a same-cycle accept: the stream is complete.
      if (consume && (count_d == DEPTH_C)) begin
        done_d  = 1'b1;
        valid_d = 1'b0;
        state_d = ST_DONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign instr_o       = instr_q;
  assign addr_o        = count_q[ADDR_W-1:0];
  assign instr_valid_o = valid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

  a_hold_stable: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (valid_q && !instr_ready_i && !clear_i)
      |=> (valid_q && $stable(instr_q) && $stable(count_q))
  );

  a_state_consistent: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (valid_q == (state_q == ST_FULL)) && (done_q == (state_q == ST_DONE))
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus hand-written sequences
// for back-pressure, illegal ops, clear priority, DEPTH completion and reset.
module tb_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;

  logic              clk_i;
  logic              rst_i;
  logic              clear_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        op_i;
  logic [4:0]        rs_i, rt_i, rd_i;
  logic [5:0]        funct_i;
  logic [15:0]       imm_i;
  logic [25:0]       target_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic              done_o;
  logic              err_o;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .op_i          (op_i),
    .rs_i          (rs_i),
    .rt_i          (rt_i),
    .rd_i          (rd_i),
    .funct_i       (funct_i),
    .imm_i         (imm_i),
    .target_i      (target_i),
    .instr_o       (instr_o),
    .addr_o        (addr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  // Words that will be taken at the coming rising edge, recorded as {addr, instr}.
  logic [ADDR_W+31:0] mon_q[$];

  always @(negedge clk_i) begin
    #1;
    if (rst_i && !clear_i && instr_valid_o && instr_ready_i)
      mon_q.push_back({addr_o, instr_o});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [25:0] target);
    op_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
    funct_i = funct; imm_i = imm; target_i = target;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic [25:0] target);
    logic acc;
    drive(op, rs, rt, rd, funct, imm, target);
    in_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready_o;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  task automatic check_word(input string name, input int idx,
                            input logic [ADDR_W-1:0] exp_addr, input logic [31:0] exp_instr);
    logic [ADDR_W+31:0] rec;
    if (idx < mon_q.size()) begin
      rec = mon_q[idx];
      check({name, "_addr"}, 32'(rec[ADDR_W+31:32]), 32'(exp_addr));
      check({name, "_instr"}, rec[31:0], exp_instr);
    end else begin
      check({name, "_present"}, 32'(mon_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int n;
    logic acc;

    rst_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; instr_ready_i = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

    // Reset state while rst_i is held low
    #1;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Encoding table; unused fields carry junk that must be ignored
    vecs[0] = '{3'd0, 5'd9,  5'd10, 5'd8,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h012A4020};
    vecs[1] = '{3'd3, 5'd29, 5'd8,  5'd31, 6'h3F, 16'h0004, 26'h1234567, 32'h8FA80004};
    vecs[2] = '{3'd1, 5'd0,  5'd8,  5'd0,  6'h00, 16'h00FF, 26'h0000000, 32'h340800FF};
    vecs[3] = '{3'd2, 5'd0,  5'd8,  5'd17, 6'h15, 16'h0005, 26'h2AAAAAA, 32'h20080005};
    vecs[4] = '{3'd4, 5'd29, 5'd8,  5'd3,  6'h07, 16'h0000, 26'h0000001, 32'hAFA80000};
    vecs[5] = '{3'd5, 5'd8,  5'd9,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 32'h1109FFFF};
    vecs[6] = '{3'd6, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000};
    vecs[7] = '{3'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000000, 32'h03FFF83F};
    vecs[8] = '{3'd2, 5'd31, 5'd0,  5'd5,  6'h11, 16'h8000, 26'h1555555, 32'h23E08000};
    vecs[9] = '{3'd6, 5'd7,  5'd7,  5'd7,  6'h01, 16'h1234, 26'h3FFFFFF, 32'h0BFFFFFF};

    instr_ready_i = 1'b1;
    foreach (vecs[i]) begin
      do_clear();
      check("vec_valid_before", 32'(instr_valid_o), 32'd0);
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct,
           vecs[i].imm, vecs[i].target);
      check($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid_o), 32'd1);
      check($sformatf("vec%0d_addr", i), 32'(addr_o), 32'd0);
    end

    // ADDI: valid for one cycle, then consumed and address advances
    do_clear();
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0);
    check("addi_instr", instr_o, 32'h20080005);
    @(negedge clk_i);
    check("addi_valid_after", 32'(instr_valid_o), 32'd0);
    check("addi_addr_after", 32'(addr_o), 32'd1);

    // Back-to-back stream, then BEQ held under back-pressure until count hits DEPTH
    do_clear();
    mon_q.delete();
    instr_ready_i = 1'b1;
    send(3'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0);
    send(3'd3, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0);
    send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h00FF, 26'd0);
    @(negedge clk_i);
    instr_ready_i = 1'b0;
    send(3'd5, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    for (int c = 0; c < 3; c++) begin
      check("beq_hold_instr", instr_o, 32'h1109FFFF);
      check("beq_hold_addr", 32'(addr_o), 32'd3);
      check("beq_hold_valid", 32'(instr_valid_o), 32'd1);
      check("beq_hold_in_ready", 32'(in_ready_o), 32'd0);
      @(negedge clk_i);
    end
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    #2;
    check("stream_done", 32'(done_o), 32'd1);
    check("stream_in_ready", 32'(in_ready_o), 32'd0);
    check("stream_valid", 32'(instr_valid_o), 32'd0);
    check("stream_count", 32'(mon_q.size()), 32'd4);
    check_word("stream0", 0, 6'd0, 32'h012A4020);
    check_word("stream1", 1, 6'd1, 32'h8FA80004);
    check_word("stream2", 2, 6'd2, 32'h340800FF);
    check_word("stream3", 3, 6'd3, 32'h1109FFFF);

    // J, illegal op consumed alongside it, then SW with no address gap
    do_clear();
    mon_q.delete();
    instr_ready_i = 1'b1;
    send(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000);
    check("j_err_before", 32'(err_o), 32'd0);
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hABCD, 26'h1234567);
    check("ill_err", 32'(err_o), 32'd1);
    check("ill_valid", 32'(instr_valid_o), 32'd0);
    check("ill_addr", 32'(addr_o), 32'd1);
    send(3'd4, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0000, 26'd0);
    check("sw_instr", instr_o, 32'hAFA80000);
    check("sw_addr", 32'(addr_o), 32'd1);
    @(negedge clk_i);
    #2;
    check("jsw_count", 32'(mon_q.size()), 32'd2);
    check_word("jsw0", 0, 6'd0, 32'h08100000);
    check_word("jsw1", 1, 6'd1, 32'hAFA80000);

    // Illegal op while empty leaves output state untouched
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    check("ill_empty_valid", 32'(instr_valid_o), 32'd0);
    check("ill_empty_addr", 32'(addr_o), 32'd2);
    check("ill_empty_instr", instr_o, 32'hAFA80000);
    check("ill_empty_err", 32'(err_o), 32'd1);

    // clear_i beats a same-cycle consume and accept
    do_clear();
    check("clear_err", 32'(err_o), 32'd0);
    instr_ready_i = 1'b1;
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0001, 26'd0);
    drive(3'd3, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0);
    in_valid_i = 1'b1;
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    in_valid_i = 1'b0;
    check("clrpri_valid", 32'(instr_valid_o), 32'd0);
    check("clrpri_addr", 32'(addr_o), 32'd0);
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0002, 26'd0);
    check("clrpri_next_addr", 32'(addr_o), 32'd0);
    check("clrpri_next_instr", instr_o, 32'h20080002);

    // Stream ADDIs at full rate until DEPTH words are out
    do_clear();
    mon_q.delete();
    instr_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'(n), 26'd0);
      in_valid_i = 1'b1;
      acc = in_ready_o;
      @(negedge clk_i);
      if (acc) n++;
    end
    in_valid_i = 1'b0;
    #2;
    check("depth_done", 32'(done_o), 32'd1);
    check("depth_in_ready", 32'(in_ready_o), 32'd0);
    check("depth_valid", 32'(instr_valid_o), 32'd0);
    check("depth_count", 32'(mon_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_word($sformatf("depth%0d", i), i, 6'(i), 32'h20080000 | 32'(i));
    @(negedge clk_i);
    @(negedge clk_i);
    check("depth_done_sticky", 32'(done_o), 32'd1);
    do_clear();
    check("depth_clr_addr", 32'(addr_o), 32'd0);
    check("depth_clr_done", 32'(done_o), 32'd0);
    check("depth_clr_in_ready", 32'(in_ready_o), 32'd1);

    // Asynchronous reset while a word is held
    do_clear();
    instr_ready_i = 1'b1;
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0003, 26'd0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    instr_ready_i = 1'b0;
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0);
    check("prerst_addr", 32'(addr_o), 32'd1);
    check("prerst_valid", 32'(instr_valid_o), 32'd1);
    check("prerst_err", 32'(err_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_addr", 32'(addr_o), 32'd0);
    check("arst_err", 32'(err_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_instr", instr_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready_o), 32'd1);
    check("postrst_valid", 32'(instr_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
